// File: rtl/vga_patt_sched.sv
// Frame-synchronous selector that picks one of two 3-bit pattern colours for the VGA driver.
// A debounced manual switch or auto rotation changes the pattern only at frame starts, optionally through black frames.
module vga_patt_sched #(
   parameter int DEB_CYCLES      = 500000,
   parameter int FRAMES_PER_PATT = 60,
   parameter int BLANK_FRAMES    = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       sw_0,
   input  logic       auto_en_i,
   input  logic       vSync_i,
   input  logic [2:0] rgb_a_i,
   input  logic [2:0] rgb_b_i,
   output logic [2:0] rgb_o,
   output logic       sel_o,
   output logic       blank_o,
   output logic [7:0] frame_cnt_o
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int AW = (FRAMES_PER_PATT > 1) ? $clog2(FRAMES_PER_PATT) : 1;
   localparam int BW = 4;

   typedef enum logic [1:0] {
      SHOW  = 2'd0,
      PEND  = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            sw_s1;
   logic            sw_s2;
   logic            vs_s1;
   logic            vs_s2;
   logic            vs_s3;
   logic            deb;
   logic [DW-1:0]   deb_cnt;
   logic [AW-1:0]   auto_cnt;
   logic [BW-1:0]   blank_cnt;
   logic [BW-1:0]   blank_cnt_nx;
   logic            pend_sel;
   logic            pend_sel_nx;
   logic            sel_nx;
   logic            blank_nx;
   logic            frame_start;
   logic            differ;
   logic            deb_done;
   logic            auto_term;
   logic            target;
   logic            switch_done;

   // vs_s3 holds the previous synchronised vSync so a 1->0 step marks the frame boundary.
   assign frame_start = vs_s3 & ~vs_s2;
   assign differ      = (sw_s2 != deb);
   assign deb_done    = differ && (deb_cnt == DW'(DEB_CYCLES - 1));
   assign auto_term   = auto_en_i && frame_start && (auto_cnt == AW'(FRAMES_PER_PATT - 1));
   assign target      = auto_en_i ? sel_o : deb;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sw_s1 <= 1'b1;
         sw_s2 <= 1'b1;
         vs_s1 <= 1'b1;
         vs_s2 <= 1'b1;
         vs_s3 <= 1'b1;
      end else begin
         sw_s1 <= sw_0;
         sw_s2 <= sw_s1;
         vs_s1 <= vSync_i;
         vs_s2 <= vs_s1;
         vs_s3 <= vs_s2;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         deb     <= 1'b1;
         deb_cnt <= '0;
      end else if (deb_done) begin
         deb     <= sw_s2;
         deb_cnt <= '0;
      end else if (differ) begin
         deb_cnt <= deb_cnt + 1'b1;
      end else begin
         deb_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         frame_cnt_o <= 8'd0;
      end else if (frame_start) begin
         frame_cnt_o <= frame_cnt_o + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || !auto_en_i || switch_done) begin
         auto_cnt <= '0;
      end else if (state == SHOW && frame_start) begin
         auto_cnt <= auto_term ? '0 : auto_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= SHOW;
         sel_o     <= 1'b1;
         blank_o   <= 1'b0;
         blank_cnt <= '0;
         pend_sel  <= 1'b1;
      end else begin
         state     <= state_nx;
         sel_o     <= sel_nx;
         blank_o   <= blank_nx;
         blank_cnt <= blank_cnt_nx;
         pend_sel  <= pend_sel_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      sel_nx       = sel_o;
      blank_nx     = blank_o;
      blank_cnt_nx = blank_cnt;
      pend_sel_nx  = pend_sel;
      switch_done  = 1'b0;
      case (state)
         SHOW: begin
            // In auto mode the terminal frame start is itself the boundary, so PEND is skipped.
            if (auto_term) begin
               if (BLANK_FRAMES == 0) begin
                  sel_nx      = ~sel_o;
                  switch_done = 1'b1;
               end else begin
                  state_nx     = BLANK;
                  blank_nx     = 1'b1;
                  blank_cnt_nx = BW'(BLANK_FRAMES);
                  pend_sel_nx  = ~sel_o;
               end
            end else if (target != sel_o) begin
               state_nx = PEND;
            end
         end
         PEND: begin
            if (target == sel_o) begin
               state_nx = SHOW;
            end else if (frame_start) begin
               if (BLANK_FRAMES == 0) begin
                  sel_nx      = target;
                  state_nx    = SHOW;
                  switch_done = 1'b1;
               end else begin
                  state_nx     = BLANK;
                  blank_nx     = 1'b1;
                  blank_cnt_nx = BW'(BLANK_FRAMES);
                  pend_sel_nx  = target;
               end
            end
         end
         BLANK: begin
            if (frame_start) begin
               if (blank_cnt == BW'(1)) begin
                  sel_nx      = pend_sel;
                  blank_nx    = 1'b0;
                  state_nx    = SHOW;
                  switch_done = 1'b1;
               end else begin
                  blank_cnt_nx = blank_cnt - 1'b1;
               end
            end
         end
         default: begin
            state_nx = SHOW;
         end
      endcase
   end

   assign rgb_o = blank_o ? 3'b000 : (sel_o ? rgb_a_i : rgb_b_i);

endmodule
